// File: rtl/usb_reg_bus_pkg.sv
// Shared types and constants for the USB host register-bus initiator.
package usb_reg_bus_pkg;

  localparam int unsigned TMO_W = 8;
  localparam logic [7:0] IRQ_STATUS_ADDR_DEFAULT = 8'h09;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_BUS,
    ST_CMD_RSP,
    ST_IRQ_RD,
    ST_IRQ_WR,
    ST_IRQ_RPT,
    ST_GAP
  } state_t;

endpackage

// File: rtl/usb_reg_bus_master.sv
// Strobe/ack register-bus initiator for the USB host core: executes single
// commands from a valid/ready stream and services the host interrupt by
// reading the status register and writing the value back to clear it.
module usb_reg_bus_master
  import usb_reg_bus_pkg::*;
#(
  parameter logic [7:0]  IRQ_STATUS_ADDR = IRQ_STATUS_ADDR_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_we_i,
  input  logic [7:0] cmd_addr_i,
  input  logic [7:0] cmd_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       rsp_err_o,
  input  logic       irq_i,
  output logic       irq_valid_o,
  output logic [7:0] irq_status_o,
  output logic       irq_err_o,
  output logic [7:0] address_o,
  output logic [7:0] data_o,
  input  logic [7:0] data_i,
  output logic       we_o,
  output logic       strobe_o,
  input  logic       ack_i
);

  // Counter value seen during the last allowed strobe cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             live;
  logic             tmo_hit;

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // Ready is combinational so a same-cycle irq_i can withhold it; live keeps
  // it low while reset is asserted and for the first clock after release.
  assign cmd_ready_o = live && (state == ST_IDLE) && !irq_i;

  // Transaction sequencer with registered bus and response outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= ST_IDLE;
      tmo_cnt      <= '0;
      live         <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_rdata_o  <= '0;
      rsp_err_o    <= 1'b0;
      irq_valid_o  <= 1'b0;
      irq_status_o <= '0;
      irq_err_o    <= 1'b0;
      address_o    <= '0;
      data_o       <= '0;
      we_o         <= 1'b0;
      strobe_o     <= 1'b0;
    end else begin
      live        <= 1'b1;
      rsp_valid_o <= 1'b0;
      irq_valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (live && irq_i) begin
            state     <= ST_IRQ_RD;
            strobe_o  <= 1'b1;
            address_o <= IRQ_STATUS_ADDR;
            data_o    <= '0;
            we_o      <= 1'b0;
            tmo_cnt   <= '0;
          end else if (cmd_ready_o && cmd_valid_i) begin
            state     <= ST_CMD_BUS;
            strobe_o  <= 1'b1;
            address_o <= cmd_addr_i;
            data_o    <= cmd_wdata_i;
            we_o      <= cmd_we_i;
            tmo_cnt   <= '0;
          end
        end
        ST_CMD_BUS: begin
          if (ack_i) begin
            state       <= ST_CMD_RSP;
            strobe_o    <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= we_o ? '0 : data_i;
            rsp_err_o   <= 1'b0;
          end else if (tmo_hit) begin
            state       <= ST_CMD_RSP;
            strobe_o    <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_CMD_RSP: state <= ST_GAP;
        ST_IRQ_RD: begin
          // Strobe stays high straight into the write-back of the same address.
          if (ack_i) begin
            state        <= ST_IRQ_WR;
            irq_status_o <= data_i;
            data_o       <= data_i;
            we_o         <= 1'b1;
            tmo_cnt      <= '0;
          end else if (tmo_hit) begin
            state        <= ST_IRQ_RPT;
            strobe_o     <= 1'b0;
            irq_status_o <= '0;
            irq_err_o    <= 1'b1;
            irq_valid_o  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_IRQ_WR: begin
          if (ack_i || tmo_hit) begin
            state       <= ST_IRQ_RPT;
            strobe_o    <= 1'b0;
            irq_err_o   <= !ack_i;
            irq_valid_o <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_IRQ_RPT: state <= ST_GAP;
        ST_GAP:     state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_reg_bus_master.sv
// Scoreboard bench for usb_reg_bus_master: a bus slave model driven from a
// queue of expected transactions, plus response and IRQ report queues.
module tb_usb_reg_bus_master;

  localparam int unsigned TMO  = 255;
  localparam logic [7:0]  IRQA = 8'h09;

  typedef struct {
    logic [7:0]  addr;
    logic        we;
    logic [7:0]  wdata;
    int unsigned delay;   // strobe cycle carrying ack; 0 = never ack
    logic [7:0]  rdata;
    logic        cont;    // strobe expected to stay high after completion
  } bus_t;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } rsp_t;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic       cmd_we_i = 1'b0;
  logic [7:0] cmd_addr_i = '0;
  logic [7:0] cmd_wdata_i = '0;
  logic       rsp_valid_o;
  logic [7:0] rsp_rdata_o;
  logic       rsp_err_o;
  logic       irq_i = 1'b0;
  logic       irq_valid_o;
  logic [7:0] irq_status_o;
  logic       irq_err_o;
  logic [7:0] address_o;
  logic [7:0] data_o;
  logic [7:0] data_i = '0;
  logic       we_o;
  logic       strobe_o;
  logic       ack_i = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  bus_t bq[$];
  rsp_t rq[$];
  rsp_t iq[$];
  int   bptr = 0, rptr = 0, iptr = 0;
  int unsigned run = 0;
  bit   bad = 1'b0, pend = 1'b0, unexp = 1'b0;
  int unsigned flush_cnt = 0, flush_seen = 0;

  usb_reg_bus_master #(.IRQ_STATUS_ADDR(IRQA), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .irq_i(irq_i), .irq_valid_o(irq_valid_o), .irq_status_o(irq_status_o),
    .irq_err_o(irq_err_o), .address_o(address_o), .data_o(data_o),
    .data_i(data_i), .we_o(we_o), .strobe_o(strobe_o), .ack_i(ack_i)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned blen(input bus_t b);
    return (b.delay != 0) ? b.delay : TMO;
  endfunction

  task automatic push_bus(input logic [7:0] addr, input logic we, input logic [7:0] wdata,
                          input int unsigned delay, input logic [7:0] rdata, input logic cont);
    bus_t b;
    b = '{addr, we, wdata, delay, rdata, cont};
    bq.push_back(b);
  endtask

  task automatic push_rsp(input logic [7:0] data, input logic err, input bit is_irq);
    rsp_t r;
    r = '{data, err};
    if (is_irq) iq.push_back(r);
    else        rq.push_back(r);
  endtask

  // Bus slave model and bus-side checker, advanced once per cycle.
  always @(negedge clk) begin
    if (flush_seen != flush_cnt) begin
      flush_seen = flush_cnt;
      bptr = bq.size();
      run = 0; bad = 1'b0; pend = 1'b0;
    end
    if (pend) begin
      check("bus_len", run, blen(bq[bptr]));
      check("bus_fields", {31'd0, bad}, 0);
      check("bus_strobe_after", {31'd0, strobe_o}, {31'd0, bq[bptr].cont});
      bptr++; pend = 1'b0; run = 0; bad = 1'b0;
    end
    ack_i = 1'b0;
    if (strobe_o) begin
      if (bptr >= bq.size()) begin
        if (!unexp) check("bus_unexpected", 1, 0);
        unexp = 1'b1;
      end else begin
        run++;
        if (address_o !== bq[bptr].addr || we_o !== bq[bptr].we ||
            (bq[bptr].we && data_o !== bq[bptr].wdata)) bad = 1'b1;
        data_i = bq[bptr].rdata;
        if (run == bq[bptr].delay) begin
          ack_i = 1'b1;
          pend  = 1'b1;
        end else if (run == TMO) begin
          pend = 1'b1;
        end
      end
    end else if (run != 0) begin
      check("bus_early_drop", run, blen(bq[bptr]));
      bptr++; run = 0; bad = 1'b0;
    end
  end

  // Command response scoreboard.
  always @(negedge clk) begin
    if (rsp_valid_o) begin
      if (rptr >= rq.size()) check("rsp_unexpected", 1, 0);
      else begin
        check("rsp_rdata", rsp_rdata_o, rq[rptr].data);
        check("rsp_err", rsp_err_o, rq[rptr].err);
        rptr++;
      end
    end
  end

  // IRQ report scoreboard.
  always @(negedge clk) begin
    if (irq_valid_o) begin
      if (iptr >= iq.size()) check("irq_unexpected", 1, 0);
      else begin
        check("irq_status", irq_status_o, iq[iptr].data);
        check("irq_err", irq_err_o, iq[iptr].err);
        iptr++;
      end
    end
  end

  task automatic wait_ready();
    int unsigned i;
    for (i = 0; i < 600; i++) begin
      if (cmd_ready_o) break;
      @(negedge clk);
    end
    if (i == 600) check("wait_ready_timeout", 1, 0);
  endtask

  task automatic wait_drain(input string tag);
    int unsigned i;
    for (i = 0; i < 1000; i++) begin
      if (bptr == bq.size() && rptr == rq.size() && iptr == iq.size() && cmd_ready_o) break;
      @(negedge clk);
    end
    check(tag, (i < 1000) ? 1 : 0, 1);
  endtask

  task automatic do_cmd(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                        input int unsigned delay, input logic [7:0] rd);
    int unsigned len, n, rsp_at;
    len = (delay != 0) ? delay : TMO;
    push_bus(addr, we, wdata, delay, rd, 1'b0);
    push_rsp((we || delay == 0) ? 8'h00 : rd, delay == 0, 1'b0);
    wait_ready();
    cmd_we_i = we; cmd_addr_i = addr; cmd_wdata_i = wdata; cmd_valid_i = 1'b1;
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
    n = 0; rsp_at = 0;
    while (n < len + 20) begin
      @(negedge clk);
      n++;
      if (rsp_valid_o) rsp_at = n;
      if (cmd_ready_o) break;
    end
    check("rsp_cycle", rsp_at, len + 1);
    check("ready_cycle", n, len + 3);
  endtask

  task automatic wait_irq_drop();
    int unsigned i;
    for (i = 0; i < 600; i++) begin
      @(negedge clk);
      if (irq_valid_o) break;
    end
    irq_i = 1'b0;
    check("irq_seen", (i < 600) ? 1 : 0, 1);
  endtask

  initial begin
    bit accepted, early, irq_done;
    int unsigned n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready_o, 0);
    check("rst_strobe", strobe_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_irq_valid", irq_valid_o, 0);
    check("rst_addr", address_o, 0);
    check("rst_irq_status", irq_status_o, 0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_rst", cmd_ready_o, 1);

    // Write 3C to 01, ack on second strobe cycle
    do_cmd(1'b1, 8'h01, 8'h3C, 2, 8'hFF);
    // Read 0A, ack on first strobe cycle
    do_cmd(1'b0, 8'h0A, 8'h00, 1, 8'h5A);
    do_cmd(1'b0, 8'hC3, 8'h00, 4, 8'hA5);

    // IRQ service: read 05 from 09, write it back
    push_bus(IRQA, 1'b0, 8'h00, 1, 8'h05, 1'b1);
    push_bus(IRQA, 1'b1, 8'h05, 2, 8'h00, 1'b0);
    push_rsp(8'h05, 1'b0, 1'b1);
    irq_i = 1'b1;
    wait_irq_drop();
    repeat (10) @(negedge clk);
    check("irq_no_repeat", strobe_o, 0);
    wait_drain("irq_drain");

    // Command timeout, then ack on the last allowed cycle
    do_cmd(1'b0, 8'h22, 8'h00, 0, 8'hAA);
    do_cmd(1'b0, 8'h23, 8'h00, TMO, 8'h77);

    // IRQ read timeout: no write-back, status 00 with error
    push_bus(IRQA, 1'b0, 8'h00, 0, 8'hEE, 1'b0);
    push_rsp(8'h00, 1'b1, 1'b1);
    irq_i = 1'b1;
    wait_irq_drop();
    wait_drain("irq_tmo_drain");

    // IRQ and command arrive together: IRQ first, command after GAP
    push_bus(IRQA, 1'b0, 8'h00, 1, 8'h11, 1'b1);
    push_bus(IRQA, 1'b1, 8'h11, 1, 8'h00, 1'b0);
    push_rsp(8'h11, 1'b0, 1'b1);
    push_bus(8'h30, 1'b1, 8'h66, 3, 8'h00, 1'b0);
    push_rsp(8'h00, 1'b0, 1'b0);
    irq_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 8'h30; cmd_wdata_i = 8'h66; cmd_valid_i = 1'b1;
    #1 check("coll_ready0", cmd_ready_o, 0);
    accepted = 1'b0; early = 1'b0; irq_done = 1'b0; n = 0;
    while (!accepted && n < 100) begin
      @(negedge clk);
      n++;
      if (irq_valid_o) begin irq_i = 1'b0; irq_done = 1'b1; end
      if (cmd_ready_o) begin
        if (!irq_done) early = 1'b1;
        @(posedge clk);
        #1 cmd_valid_i = 1'b0;
        accepted = 1'b1;
      end
    end
    check("coll_no_early_ready", {31'd0, early}, 0);
    check("coll_accepted", {31'd0, accepted}, 1);
    wait_drain("coll_drain");

    // Reset in the middle of a strobe
    push_bus(8'h40, 1'b1, 8'h99, 0, 8'h00, 1'b0);
    wait_ready();
    cmd_we_i = 1'b1; cmd_addr_i = 8'h40; cmd_wdata_i = 8'h99; cmd_valid_i = 1'b1;
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_strobe", strobe_o, 1);
    #2 rst_i = 1'b0;
    flush_cnt++;
    #1 check("async_rst_strobe", strobe_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_ready", cmd_ready_o, 1);
    repeat (5) @(negedge clk);
    check("post_rst_no_rsp", rsp_valid_o, 0);
    wait_drain("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/usb_reg_bus_master.md
Name: usb_reg_bus_master

Overview:
- Initiator for the 8-bit strobe/ack register bus that the USB host core exposes (address, data, we, strobe, ack).
- Turns a valid/ready command stream from the system side into single bus transactions, with timeout detection.
- When irq is asserted, reads the host interrupt-status register and writes the same value back (write-1-to-clear), then reports the status word.
- Sits between the system controller and the USB host wrapper.

Parameters:
- IRQ_STATUS_ADDR, 8'h09: address of the host interrupt-status register, used by the automatic IRQ service.
- TIMEOUT_CYCLES, 255: strobe cycles without ack before a transaction aborts; legal range 1..255.

Ports:
- clk_i  in  1  single clock for all logic.
- rst_i  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_we_i  in  1  1=write, 0=read.
- cmd_addr_i  in  8  register address.
- cmd_wdata_i  in  8  write data.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_rdata_o  out  8  read data; valid with rsp_valid_o; 8'h00 for writes and timeouts.
- rsp_err_o  out  1  timeout flag; valid with rsp_valid_o.
- irq_i  in  1  level interrupt from the USB host.
- irq_valid_o  out  1  one-cycle pulse; irq_status_o is valid.
- irq_status_o  out  8  captured interrupt-status value.
- irq_err_o  out  1  IRQ service timed out; valid with irq_valid_o.
- address_o  out  8  bus address.
- data_o  out  8  bus write data.
- data_i  in  8  bus read data.
- we_o  out  1  bus write enable.
- strobe_o  out  1  bus strobe.
- ack_i  in  1  bus acknowledge.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including cmd_ready_o; timeout counter 0; captured registers 0.
- States: IDLE, CMD_BUS, CMD_RSP, IRQ_RD, IRQ_WR, IRQ_RPT, GAP.
- IDLE:
  - If irq_i=1, go to IRQ_RD. IRQ has priority; cmd_ready_o=0 that cycle.
  - Otherwise cmd_ready_o=1. On cmd_valid_i, latch addr/wdata/we and go to CMD_BUS.
- Bus drive rules:
  - While in CMD_BUS, IRQ_RD or IRQ_WR, strobe_o=1.
  - address_o, data_o and we_o are registered and stable for the whole strobe.
  - The transaction completes on the first rising edge where ack_i=1; data_i is captured at that edge.
  - strobe_o drops the next cycle.
  - ack_i while strobe_o=0 is ignored.
- Timeout:
  - The 8-bit counter clears on entry to each bus state and increments on every strobe cycle without ack.
  - When it reaches TIMEOUT_CYCLES, the transaction aborts: strobe_o drops and the error is flagged.
  - An ack on the same cycle the limit is reached wins (no error).
- CMD_BUS -> CMD_RSP: rsp_valid_o=1 for one cycle with rdata/err, then GAP.
- IRQ_RD -> IRQ_WR on ack: write address IRQ_STATUS_ADDR with the captured value.
  - Timeout in IRQ_RD skips the write and goes to IRQ_RPT with err=1, status=8'h00.
- IRQ_WR -> IRQ_RPT on ack or timeout; a timeout here sets irq_err_o=1.
- IRQ_RPT: irq_valid_o=1 for one cycle, then GAP.
- GAP: one idle cycle with strobe_o=0 and cmd_ready_o=0, then IDLE. This guarantees at least one strobe-low cycle between transactions.
- If irq_i is still high after the service, it is re-serviced on return to IDLE. A level that the write failed to clear simply repeats the service.
- Latency: accept at cycle 0; strobe_o high cycles 1..k (ack at k); rsp_valid_o at k+1; GAP at k+2; cmd_ready_o at k+3.
- Reset mid-transaction drops strobe immediately; no response is issued.

Decomposition:
- Shared package usb_reg_bus_pkg: state enum, default IRQ_STATUS_ADDR, and the timeout counter width constant (8).
- Single module; no sub-module is needed. The timeout counter is inline.

Test Plan:
- Write 8'h3C to 8'h01, ack_i raised 2 cycles into the strobe -> strobe_o high exactly 2 cycles with addr 01/data 3C/we 1; rsp_valid_o pulse with err 0 and rdata 00.
- Read 8'h0A, bus returns data_i=8'h5A with ack on the first strobe cycle -> rsp_rdata_o=5A, err 0; cmd_ready_o returns 3 cycles after the ack.
- irq_i=1 with status 8'h05 -> read of 09, then write of 05 to 09; irq_valid_o pulse with irq_status_o=05. Deassert irq_i after the write -> no second service.
- Never ack, TIMEOUT_CYCLES=255 -> strobe_o high exactly 255 cycles; rsp_valid_o with rsp_err_o=1, rdata 00. Also check ack on cycle 255 -> no error.
- cmd_valid_i and irq_i both rising in the same IDLE cycle -> IRQ serviced first, cmd_ready_o held 0; command accepted after GAP.
- rst_i low while strobe_o high -> strobe_o=0 asynchronously; after release, cmd_ready_o=1 and no stale rsp_valid_o.
